rob_ctrl: RTL and testbench
===========================

# rob_ctrl

Sequencing controller for the reorder-buffer entry register file. It owns head/tail pointers, occupancy, and per-entry valid/done bits. It hands out entry tags at decode, records completion, and retires entries in order at commit. It drives the per-entry write enables, addresses and active-high per-entry clears of the ROB register array, and sits between decode, execute completion and the commit stage.

## Interface
Parameters:
- ROBsize, 32, number of ROB entries; any value ≥ 2, not required to be a power of two
- addrSize, $clog2(ROBsize), entry tag width

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous, active-low reset; one clock domain
- alloc_req_i  in  1  decode requests one entry this cycle
- alloc_ready_o  out  1  entry available; high when count < ROBsize
- alloc_tag_o  out  addrSize  tag granted; equals tail
- decodeWriteEn_o  out  1  alloc_req_i & alloc_ready_o & ~flush_i
- decodeWriteAddr_o  out  addrSize  equals tail
- complete_valid_i  in  1  an execute unit reports completion
- complete_tag_i  in  addrSize  tag being completed
- completionWriteEn_o  out  1  complete_valid_i & valid[complete_tag_i] & ~flush_i
- completionWriteAddr_o  out  addrSize  equals complete_tag_i
- commit_valid_o  out  1  valid[head] & done[head]
- commit_ready_i  in  1  commit stage accepts the head entry
- commitReadAddr_o  out  addrSize  equals head
- flush_i  in  1  discard all in-flight entries
- resets_o  out  ROBsize  active-high per-entry clear to the ROB register array
- count_o  out  addrSize+1  current occupancy

## Operation
- State: head, tail (addrSize), count (addrSize+1), valid[ROBsize], done[ROBsize].
- **Allocate:** fires when decodeWriteEn_o is high.
  - At the edge: valid[tail] set, done[tail] cleared, tail advances.
- **Complete:** fires when completionWriteEn_o is high.
  - At the edge: done[complete_tag_i] set.
  - Completion to an invalid entry: ignored, and no write enable is issued.
  - Completion to an entry that is already done: the write enable is still issued, and done stays 1.
- **Commit:** fires when commit_valid_o & commit_ready_i & ~flush_i.
  - resets_o[head] is asserted in the same cycle.
  - At the edge: valid[head] and done[head] cleared, head advances.
- **Pointer wrap:** a pointer at ROBsize-1 advances to 0, by explicit compare, not by modular overflow.
- **Count update:** +1 on allocate only, -1 on commit only, unchanged when both or neither fire.
- **Full (count == ROBsize):** alloc_ready_o low. A commit in the same cycle does not enable allocation; alloc_ready_o rises the next cycle.
- **Empty (count == 0):** commit_valid_o low. A simultaneous allocate does not bypass to commit.
- **Flush:** has priority over allocate, complete and commit in the same cycle.
  - resets_o is all ones and all write enables are low.
  - At the edge: head = tail = count = 0, and all valid and done bits clear.
- **Reset:** while reset_n_i is low, resets_o is all ones and all enables are low.
  - At the edge: same state as flush.
  - Reset mid-operation discards everything. Reset has priority over flush.
- **Reset values:** alloc_ready_o 1, alloc_tag_o 0, commit_valid_o 0, count_o 0, all addresses 0, resets_o all ones during reset and all zeros after.

## Timing
- All outputs are combinational from registered state plus the same-cycle inputs listed above. There are no combinational paths from commit_ready_i to alloc_ready_o.
- **Allocate to complete:** a tag granted in cycle N is completable from cycle N+1.
- **Complete to commit:** completion in cycle N gives commit_valid_o no earlier than N+1.
- **Sustained throughput:** one allocate, one completion and one commit per cycle.
- resets_o[head] is a single-cycle pulse aligned with the commit handshake. The array clears on the same edge at which head advances.

## Structure
- **Package rob_pkg:** ROB_SIZE, ROB_ADDR_W, typedef robTag_t (logic [ROB_ADDR_W-1:0]), typedef robCount_t (logic [ROB_ADDR_W:0]).
- **Sub-module rob_ptr:** wrapping pointer register with inputs advance and clear, instantiated twice (head and tail). Valid/done vectors and count stay in rob_ctrl.

## Test plan
- **Reset:** hold reset_n_i low 2 cycles with alloc_req_i=1 -> resets_o=all ones, decodeWriteEn_o=0. After release: count_o=0, alloc_tag_o=0, alloc_ready_o=1.
- **Fill:** ROBsize=8, allocate 8 times back-to-back -> tags 0..7, count_o=8, alloc_ready_o=0. A 9th request gets no decodeWriteEn_o.
- **Out-of-order complete:** complete tags 2,0,1 in that order -> commit_valid_o first high one cycle after tag 0 completes. Commits retire 0,1,2 in order, with resets_o=0x01, 0x02, 0x04 in the respective commit cycles.
- **Full-edge simultaneity:** with 8 entries and head done, assert commit_ready_i and alloc_req_i together -> commit fires, allocate blocked, count_o=7. The next cycle's allocate gets tag 0 (wrap), count_o=8.
- **Stray and flush:** complete_tag_i=5 while entry 5 is invalid -> completionWriteEn_o=0, state unchanged. Then flush_i with count 4 and commit_ready_i=1 -> resets_o=0xFF, no commit. The next cycle shows count_o=0, head=tail=0.
- **Streaming:** steady state with one allocate, one complete and one commit per cycle for 20 cycles -> count_o constant, tags wrap 7->0, no lost or duplicated commit.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared sizing and types for the reorder-buffer sequencing controller.
package rob_pkg;

  localparam int ROB_SIZE   = 32;
  localparam int ROB_ADDR_W = $clog2(ROB_SIZE);

  typedef logic [ROB_ADDR_W-1:0] robTag_t;
  typedef logic [ROB_ADDR_W:0]   robCount_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrapping pointer register for the ROB head/tail.
// The pointer steps to 0 after SIZE-1 by explicit compare, so SIZE need not
// be a power of two.
module rob_ptr #(
  parameter int SIZE = 32,
  parameter int W    = $clog2(SIZE)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         advance,
  input  logic         clear,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST = W'(SIZE - 1);

  // Pointer register: reset/clear to 0, otherwise advance with wrap.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (ptr == LAST) ? '0 : ptr + W'(1);
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// Reorder-buffer sequencing controller.
// Hands out tags at decode (tail), records completion into per-entry done
// bits, and retires the head entry in order once it is valid and done.
// Handshakes: an allocate fires on alloc_req_i & alloc_ready_o; a commit
// fires on commit_valid_o & commit_ready_i; flush_i and reset both suppress
// every firing in their cycle and pulse all per-entry clears.
module rob_ctrl
  import rob_pkg::*;
#(
  parameter int ROBsize  = ROB_SIZE,
  parameter int addrSize = $clog2(ROBsize)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                alloc_req_i,
  output logic                alloc_ready_o,
  output logic [addrSize-1:0] alloc_tag_o,
  output logic                decodeWriteEn_o,
  output logic [addrSize-1:0] decodeWriteAddr_o,
  input  logic                complete_valid_i,
  input  logic [addrSize-1:0] complete_tag_i,
  output logic                completionWriteEn_o,
  output logic [addrSize-1:0] completionWriteAddr_o,
  output logic                commit_valid_o,
  input  logic                commit_ready_i,
  output logic [addrSize-1:0] commitReadAddr_o,
  input  logic                flush_i,
  output logic [ROBsize-1:0]  resets_o,
  output logic [addrSize:0]   count_o
);

  // Tag space may exceed ROBsize when ROBsize is not a power of two; the
  // padded copy of valid reads 0 for tags that name no real entry.
  localparam int                TAG_SPACE = 1 << addrSize;
  localparam logic [addrSize:0] FULL_CNT  = (addrSize + 1)'(ROBsize);
  localparam logic [addrSize:0] CNT_ONE   = (addrSize + 1)'(1);

  logic [addrSize-1:0]  head;
  logic [addrSize-1:0]  tail;
  logic [addrSize:0]    count;
  logic [ROBsize-1:0]   valid;
  logic [ROBsize-1:0]   done;
  logic [TAG_SPACE-1:0] valid_ext;

  logic alloc_fire;
  logic complete_fire;
  logic commit_fire;
  logic wipe;

  assign wipe      = !reset_n_i || flush_i;
  assign valid_ext = TAG_SPACE'(valid);

  // Ready depends only on registered occupancy, so a commit in a full cycle
  // cannot open allocation until the following cycle.
  assign alloc_ready_o  = (count != FULL_CNT);
  assign alloc_fire     = alloc_req_i && alloc_ready_o && !wipe;
  assign complete_fire  = complete_valid_i && valid_ext[complete_tag_i] && !wipe;
  assign commit_valid_o = reset_n_i && valid[head] && done[head];
  assign commit_fire    = commit_valid_o && commit_ready_i && !flush_i;

  assign decodeWriteEn_o       = alloc_fire;
  assign completionWriteEn_o   = complete_fire;
  assign alloc_tag_o           = tail;
  assign decodeWriteAddr_o     = tail;
  assign completionWriteAddr_o = complete_tag_i;
  assign commitReadAddr_o      = head;
  assign count_o               = count;

  rob_ptr #(.SIZE(ROBsize), .W(addrSize)) u_head (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .advance (commit_fire),
    .clear   (flush_i),
    .ptr     (head)
  );

  rob_ptr #(.SIZE(ROBsize), .W(addrSize)) u_tail (
    .clk     (clk_i),
    .reset_n (reset_n_i),
    .advance (alloc_fire),
    .clear   (flush_i),
    .ptr     (tail)
  );

  // Per-entry clears: all entries on reset/flush, else the head on commit.
  always_comb begin
    resets_o = '0;
    if (wipe) begin
      resets_o = '1;
    end else if (commit_fire) begin
      resets_o[head] = 1'b1;
    end
  end

  // Valid/done bookkeeping; commit is applied last so it wins on the head.
  always_ff @(posedge clk_i) begin
    if (wipe) begin
      valid <= '0;
      done  <= '0;
    end else begin
      if (alloc_fire) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
      end
      if (complete_fire) begin
        done[complete_tag_i] <= 1'b1;
      end
      if (commit_fire) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
      end
    end
  end

  // Occupancy: net change of allocate minus commit.
  always_ff @(posedge clk_i) begin
    if (wipe) begin
      count <= '0;
    end else if (alloc_fire && !commit_fire) begin
      count <= count + CNT_ONE;
    end else if (commit_fire && !alloc_fire) begin
      count <= count - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_rob_ctrl.sv
// Bench for rob_ctrl with an 8-entry ROB: directed test-plan steps followed
// by randomized traffic, all checked against an in-order queue model.
module tb_rob_ctrl;

  localparam int N  = 8;
  localparam int AW = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          alloc_req;
  logic          alloc_ready;
  logic [AW-1:0] alloc_tag;
  logic          dwe;
  logic [AW-1:0] dwaddr;
  logic          complete_valid;
  logic [AW-1:0] complete_tag;
  logic          cwe;
  logic [AW-1:0] cwaddr;
  logic          commit_valid;
  logic          commit_ready;
  logic [AW-1:0] craddr;
  logic          flush;
  logic [N-1:0]  resets;
  logic [AW:0]   count;

  rob_ctrl #(.ROBsize(N)) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n),
    .alloc_req_i           (alloc_req),
    .alloc_ready_o         (alloc_ready),
    .alloc_tag_o           (alloc_tag),
    .decodeWriteEn_o       (dwe),
    .decodeWriteAddr_o     (dwaddr),
    .complete_valid_i      (complete_valid),
    .complete_tag_i        (complete_tag),
    .completionWriteEn_o   (cwe),
    .completionWriteAddr_o (cwaddr),
    .commit_valid_o        (commit_valid),
    .commit_ready_i        (commit_ready),
    .commitReadAddr_o      (craddr),
    .flush_i               (flush),
    .resets_o              (resets),
    .count_o               (count)
  );

  // ---------------- scoreboard / model ----------------
  int n_pass  = 0;
  int n_total = 0;

  int q[$];          // in-flight tags, oldest first
  bit m_done[N];
  int m_head;
  int m_tail;
  int exp_commit_q[$];  // order in which tags must retire
  int n_commits;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
  endtask

  function automatic bit in_flight(input int t);
    foreach (q[i]) if (q[i] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    exp_commit_q.delete();
    m_head = 0;
    m_tail = 0;
    for (int i = 0; i < N; i++) m_done[i] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit a, input bit cv, input int ct, input bit cr, input bit f);
    alloc_req      = a;
    complete_valid = cv;
    complete_tag   = AW'(ct);
    commit_ready   = cr;
    flush          = f;
  endtask

  // One functional cycle: check outputs against the model, clock, update model.
  task automatic cycle();
    bit          e_ready, e_dwe, e_cwe, e_cv, e_commit;
    logic [N-1:0] e_res;
    int          t;
    #1;
    e_ready  = (q.size() < N);
    e_dwe    = alloc_req && e_ready && !flush;
    e_cwe    = complete_valid && in_flight(int'(complete_tag)) && !flush;
    e_cv     = (q.size() > 0) ? m_done[q[0]] : 1'b0;
    e_commit = e_cv && commit_ready && !flush;
    if (flush) e_res = '1;
    else if (e_commit) e_res = N'(1) << m_head;
    else e_res = '0;
    chk("alloc_ready", 32'(alloc_ready), 32'(e_ready));
    chk("alloc_tag", 32'(alloc_tag), 32'(m_tail));
    chk("decode_addr", 32'(dwaddr), 32'(m_tail));
    chk("decode_we", 32'(dwe), 32'(e_dwe));
    chk("compl_we", 32'(cwe), 32'(e_cwe));
    chk("compl_addr", 32'(cwaddr), 32'(complete_tag));
    chk("commit_valid", 32'(commit_valid), 32'(e_cv));
    chk("commit_addr", 32'(craddr), 32'(m_head));
    chk("resets", 32'(resets), 32'(e_res));
    chk("count", 32'(count), 32'(q.size()));
    @(posedge clk);
    if (flush) begin
      model_clear();
    end else begin
      if (e_cwe) m_done[complete_tag] = 1'b1;
      if (e_commit) begin
        t = q.pop_front();
        m_done[t] = 1'b0;
        m_head = (m_head + 1) % N;
        n_commits++;
      end
      if (e_dwe) begin
        q.push_back(m_tail);
        m_done[m_tail] = 1'b0;
        m_tail = (m_tail + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_cycles(input int n);
    reset_n = 1'b0;
    drive(1'b1, 1'b1, 0, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("rst_resets", 32'(resets), 32'(N'('1)));
      chk("rst_decode_we", 32'(dwe), 32'd0);
      chk("rst_compl_we", 32'(cwe), 32'd0);
      chk("rst_commit_valid", 32'(commit_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    model_clear();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ct;
    int commits_before;
    reset_n = 1'b0;
    drive(1'b0, 1'b0, 0, 1'b0, 1'b0);
    n_commits = 0;
    model_clear();
    @(negedge clk);

    // Reset held 2 cycles with a pending allocate request.
    reset_cycles(2);
    #1;
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_tag", 32'(alloc_tag), 32'd0);
    chk("post_rst_ready", 32'(alloc_ready), 32'd1);
    chk("post_rst_resets", 32'(resets), 32'd0);
    @(negedge clk);

    // Fill: 8 back-to-back allocates, then a refused 9th.
    for (int i = 0; i < N; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cycle();
    end
    #1;
    chk("full_count", 32'(count), 32'(N));
    chk("full_ready", 32'(alloc_ready), 32'd0);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
    cycle();

    // Out-of-order completion 2,0,1, then three in-order commits.
    drive(1'b0, 1'b1, 2, 1'b1, 1'b0); cycle();
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0); cycle();
    #1;
    chk("ooo_cv_after_tag0", 32'(commit_valid), 32'd1);
    drive(1'b0, 1'b1, 1, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 0, 1'b1, 1'b0);
      #1;
      chk("ooo_resets", 32'(resets), 32'(1 << i));
      cycle();
    end

    // Refill to full, complete the head, then commit+allocate together.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b1, m_head, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 0, 1'b1, 1'b0);
    #1;
    chk("edge_blocked", 32'(dwe), 32'd0);
    cycle();
    #1;
    chk("edge_count7", 32'(count), 32'd7);
    drive(1'b1, 1'b0, 0, 1'b0, 1'b0); cycle();
    #1;
    chk("edge_count8", 32'(count), 32'd8);

    // Stray completion and flush with count 4.
    drive(1'b0, 1'b0, 0, 1'b0, 1'b1); cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 0, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 1'b1, 5, 1'b0, 1'b0);
    #1;
    chk("stray_we", 32'(cwe), 32'd0);
    cycle();
    drive(1'b0, 1'b1, 0, 1'b0, 1'b0); cycle();
    drive(1'b0, 1'b0, 0, 1'b1, 1'b1);
    #1;
    chk("flush_resets", 32'(resets), 32'hFF);
    cycle();
    #1;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_head", 32'(craddr), 32'd0);
    chk("flush_tail", 32'(alloc_tag), 32'd0);

    // Streaming: allocate, complete last tag, commit every cycle.
    commits_before = n_commits;
    for (int i = 0; i < 22; i++) begin
      if (q.size() > 0) drive(1'b1, 1'b1, q[q.size()-1], 1'b1, 1'b0);
      else drive(1'b1, 1'b0, 0, 1'b1, 1'b0);
      if (i >= 2) begin
        #1;
        chk("stream_count", 32'(count), 32'd2);
      end
      cycle();
    end
    chk("stream_commits", 32'(n_commits - commits_before), 32'd20);

    // Randomized traffic, with one reset mid-stream.
    for (int i = 0; i < 300; i++) begin
      if (i == 150) reset_cycles(1);
      if (q.size() > 0 && $urandom_range(0, 1) == 1)
        ct = q[$urandom_range(0, q.size() - 1)];
      else
        ct = $urandom_range(0, N - 1);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ct,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
